// File: rtl/mips_exec_unit.sv
// mips_exec_unit: MIPS integer execute stage with an internal 32-entry GPR file,
// registered single-cycle ALU writeback and an iterative multiply/divide unit (HI/LO).
// Build option: define MIPS_OVF_TRAP_EN to turn signed overflow on add/sub/addi into a
// suppressed writeback plus an ovf_trap pulse; otherwise those ops wrap.
module mips_exec_unit #(
  parameter int unsigned W        = 32,
  parameter int unsigned MUL_STEP = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  instruction,
  input  logic         load_en,
  input  logic [4:0]   load_addr,
  input  logic [W-1:0] load_data,
  output logic [W-1:0] result,
  output logic [4:0]   dest,
  output logic         result_valid,
  output logic         Zero_flag,
  output logic         illegal,
`ifdef MIPS_OVF_TRAP_EN
  output logic         ovf_trap,
`endif
  output logic         md_done
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;

  localparam int unsigned     CntW    = $clog2(W);
  localparam logic [CntW-1:0] MulLast = CntW'(W / MUL_STEP - 1);
  localparam logic [CntW-1:0] DivLast = CntW'(W - 1);
`ifdef MIPS_OVF_TRAP_EN
  localparam bit OvfTrap = 1'b1;
`else
  localparam bit OvfTrap = 1'b0;
`endif

  logic [W-1:0]    r_gpr [32];
  logic [W-1:0]    r_result, r_hi, r_lo;
  logic [4:0]      r_dest;
  logic            r_result_valid, r_zero, r_illegal, r_md_done;
  logic [1:0]      r_state;
  logic [CntW-1:0] r_cnt;
  logic            r_neg_q, r_neg_r, r_div0;
  logic [W-1:0]    r_dividend, r_mplier, r_rem, r_quo, r_dvsr;
  logic [2*W-1:0]  r_acc, r_mcand;

  logic [5:0]      w_op, w_funct;
  logic [4:0]      w_rs, w_rt, w_rd, w_shamt, w_wb_dest;
  logic [15:0]     w_imm;
  logic [W-1:0]    w_a, w_b, w_imm_se, w_imm_ze, w_lui, w_sum_rr, w_dif_rr, w_sum_ri, w_alu;
  logic            w_ovf_add, w_ovf_sub, w_ovf_addi;
  logic            w_wb, w_ovf, w_bad, w_md_start, w_md_div, w_md_signed, w_accept, w_do_wb;
  logic [W-1:0]    w_abs_a, w_abs_b, w_rem_nx, w_quo_nx;
  logic [2*W-1:0]  w_acc_nx, w_prod_fin;
  logic [W:0]      w_rem_sh, w_diff;

  assign w_op     = instruction[31:26];
  assign w_rs     = instruction[25:21];
  assign w_rt     = instruction[20:16];
  assign w_rd     = instruction[15:11];
  assign w_shamt  = instruction[10:6];
  assign w_funct  = instruction[5:0];
  assign w_imm    = instruction[15:0];

  assign w_a      = (w_rs == 5'd0) ? '0 : r_gpr[w_rs];
  assign w_b      = (w_rt == 5'd0) ? '0 : r_gpr[w_rt];
  assign w_imm_se = {{(W-16){w_imm[15]}}, w_imm};
  assign w_imm_ze = {{(W-16){1'b0}}, w_imm};
  assign w_lui    = w_imm_se << 16;
  assign w_sum_rr = w_a + w_b;
  assign w_dif_rr = w_a - w_b;
  assign w_sum_ri = w_a + w_imm_se;

  assign w_ovf_add  = (w_a[W-1] == w_b[W-1]) && (w_sum_rr[W-1] != w_a[W-1]);
  assign w_ovf_sub  = (w_a[W-1] != w_b[W-1]) && (w_dif_rr[W-1] != w_a[W-1]);
  assign w_ovf_addi = (w_a[W-1] == w_imm_se[W-1]) && (w_sum_ri[W-1] != w_a[W-1]);

  assign in_ready = (r_state == StIdle);
  assign w_accept = in_valid && in_ready && !reset;
  assign w_do_wb  = w_accept && w_wb && !(OvfTrap && w_ovf);

  // Instruction decode and single-cycle ALU
  always_comb begin
    w_alu       = '0;
    w_wb        = 1'b0;
    w_wb_dest   = w_rd;
    w_ovf       = 1'b0;
    w_bad       = 1'b0;
    w_md_start  = 1'b0;
    w_md_div    = 1'b0;
    w_md_signed = 1'b0;
    if (w_op == 6'h00) begin
      w_wb = 1'b1;
      case (w_funct)
        6'h20: begin w_alu = w_sum_rr; w_ovf = w_ovf_add; end
        6'h21: w_alu = w_sum_rr;
        6'h22: begin w_alu = w_dif_rr; w_ovf = w_ovf_sub; end
        6'h23: w_alu = w_dif_rr;
        6'h24: w_alu = w_a & w_b;
        6'h25: w_alu = w_a | w_b;
        6'h26: w_alu = w_a ^ w_b;
        6'h27: w_alu = ~(w_a | w_b);
        6'h2A: w_alu = {{(W-1){1'b0}}, $signed(w_a) < $signed(w_b)};
        6'h2B: w_alu = {{(W-1){1'b0}}, w_a < w_b};
        6'h00: w_alu = w_b << w_shamt;
        6'h02: w_alu = w_b >> w_shamt;
        6'h03: w_alu = $signed(w_b) >>> w_shamt;
        6'h10: w_alu = r_hi;
        6'h12: w_alu = r_lo;
        6'h18, 6'h19, 6'h1A, 6'h1B: begin
          w_wb        = 1'b0;
          w_md_start  = 1'b1;
          w_md_div    = w_funct[1];
          w_md_signed = !w_funct[0];
        end
        default: begin w_wb = 1'b0; w_bad = 1'b1; end
      endcase
    end else begin
      w_wb      = 1'b1;
      w_wb_dest = w_rt;
      case (w_op)
        6'h08: begin w_alu = w_sum_ri; w_ovf = w_ovf_addi; end
        6'h09: w_alu = w_sum_ri;
        6'h0A: w_alu = {{(W-1){1'b0}}, $signed(w_a) < $signed(w_imm_se)};
        6'h0B: w_alu = {{(W-1){1'b0}}, w_a < w_imm_se};
        6'h0C: w_alu = w_a & w_imm_ze;
        6'h0D: w_alu = w_a | w_imm_ze;
        6'h0E: w_alu = w_a ^ w_imm_ze;
        6'h0F: w_alu = w_lui;
        default: begin w_wb = 1'b0; w_bad = 1'b1; end
      endcase
    end
  end

  // Operand magnitudes plus one multiply step and one restoring-divide step
  always_comb begin
    w_abs_a  = (w_md_signed && w_a[W-1]) ? -w_a : w_a;
    w_abs_b  = (w_md_signed && w_b[W-1]) ? -w_b : w_b;
    w_acc_nx = r_acc;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (r_mplier[i]) w_acc_nx = w_acc_nx + (r_mcand << i);
    end
    w_prod_fin = r_neg_q ? -w_acc_nx : w_acc_nx;
    w_rem_sh   = {r_rem, r_quo[W-1]};
    w_diff     = w_rem_sh - {1'b0, r_dvsr};
    w_rem_nx   = w_diff[W] ? w_rem_sh[W-1:0] : w_diff[W-1:0];
    w_quo_nx   = {r_quo[W-2:0], !w_diff[W]};
  end

  // GPR file: the side-port load is overridden by a same-edge writeback to the same index
  always_ff @(posedge clk) begin
    if (load_en && load_addr != 5'd0) r_gpr[load_addr] <= load_data;
    if (w_do_wb && w_wb_dest != 5'd0) r_gpr[w_wb_dest] <= w_alu;
  end

  // Registered writeback and illegal-instruction pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result       <= '0;
      r_dest         <= 5'd0;
      r_result_valid <= 1'b0;
      r_zero         <= 1'b0;
      r_illegal      <= 1'b0;
    end else begin
      r_result_valid <= w_do_wb;
      r_zero         <= w_do_wb && (w_alu == '0);
      r_illegal      <= w_accept && w_bad;
      if (w_do_wb) begin
        r_result <= w_alu;
        r_dest   <= w_wb_dest;
      end
    end
  end

  // Multiply/divide sequencer; signs are applied to the magnitude result in the last step
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_md_done <= 1'b0;
    end else begin
      r_md_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_accept && w_md_start) begin
            r_state    <= w_md_div ? StDiv : StMul;
            r_cnt      <= w_md_div ? DivLast : MulLast;
            r_acc      <= '0;
            r_mcand    <= {{W{1'b0}}, w_abs_a};
            r_mplier   <= w_abs_b;
            r_rem      <= '0;
            r_quo      <= w_abs_a;
            r_dvsr     <= w_abs_b;
            r_neg_q    <= w_md_signed && (w_a[W-1] ^ w_b[W-1]);
            r_neg_r    <= w_md_signed && w_a[W-1];
            r_div0     <= (w_b == '0);
            r_dividend <= w_a;
          end
        end
        StMul: begin
          r_acc    <= w_acc_nx;
          r_mcand  <= r_mcand << MUL_STEP;
          r_mplier <= r_mplier >> MUL_STEP;
          r_cnt    <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_hi      <= w_prod_fin[2*W-1:W];
            r_lo      <= w_prod_fin[W-1:0];
            r_md_done <= 1'b1;
            r_state   <= StIdle;
          end
        end
        StDiv: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_lo      <= r_div0 ? '1 : (r_neg_q ? -w_quo_nx : w_quo_nx);
            r_hi      <= r_div0 ? r_dividend : (r_neg_r ? -w_rem_nx : w_rem_nx);
            r_md_done <= 1'b1;
            r_state   <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef MIPS_OVF_TRAP_EN
  logic r_ovf_trap;

  // One-cycle trap pulse in place of the suppressed writeback
  always_ff @(posedge clk) begin
    if (reset) r_ovf_trap <= 1'b0;
    else       r_ovf_trap <= w_accept && w_wb && w_ovf;
  end

  assign ovf_trap = r_ovf_trap;
`endif

  assign result       = r_result;
  assign dest         = r_dest;
  assign result_valid = r_result_valid;
  assign Zero_flag    = r_zero;
  assign illegal      = r_illegal;
  assign md_done      = r_md_done;

endmodule

// File: tb/tb_mips_exec_unit.sv
// Self-checking bench for mips_exec_unit (W=32, MUL_STEP=1, default build).
// A behavioural model tracks GPRs, HI/LO and the multiply/divide busy window; a negedge
// process compares every output each cycle. Directed literal checks pin the model.
module tb_mips_exec_unit;

  localparam int unsigned W = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instruction = 32'h0;
  logic        load_en = 1'b0;
  logic [4:0]  load_addr = 5'd0;
  logic [31:0] load_data = 32'h0;
  logic [31:0] result;
  logic [4:0]  dest;
  logic        result_valid, Zero_flag, illegal, md_done;

  always #5 clk = ~clk;

  mips_exec_unit #(.W(W), .MUL_STEP(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .instruction  (instruction),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .result       (result),
    .dest         (dest),
    .result_valid (result_valid),
    .Zero_flag    (Zero_flag),
    .illegal      (illegal),
    .md_done      (md_done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model state
  logic [31:0] m_gpr [32];
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  bit          m_busy = 0, m_acc = 0;
  int          m_cnt = 0;
  logic [31:0] e_res = 0;
  logic [4:0]  e_dest = 0;
  bit          e_rv = 0, e_zero = 0, e_ill = 0, e_done = 0, e_ready = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural meaning of one instruction word
  function automatic void model_decode(input logic [31:0] ins, input logic [31:0] a,
                                       input logic [31:0] b, input logic [31:0] hi,
                                       input logic [31:0] lo, output bit wb,
                                       output logic [4:0] d, output logic [31:0] v,
                                       output bit ill, output int md);
    logic [5:0]  op, fn;
    logic [31:0] se, ze;
    int sh;
    op = ins[31:26];
    fn = ins[5:0];
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'h0, ins[15:0]};
    sh = int'(ins[10:6]);
    wb = 1; ill = 0; md = 0; v = 0; d = ins[15:11];
    if (op == 6'h00) begin
      case (fn)
        6'h20, 6'h21: v = a + b;
        6'h22, 6'h23: v = a - b;
        6'h24: v = a & b;
        6'h25: v = a | b;
        6'h26: v = a ^ b;
        6'h27: v = ~(a | b);
        6'h2A: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'h2B: v = (a < b) ? 32'd1 : 32'd0;
        6'h00: v = b << sh;
        6'h02: v = b >> sh;
        6'h03: v = $signed(b) >>> sh;
        6'h10: v = hi;
        6'h12: v = lo;
        6'h18, 6'h19, 6'h1A, 6'h1B: begin wb = 0; md = int'(fn) - 'h17; end
        default: begin wb = 0; ill = 1; end
      endcase
    end else begin
      d = ins[20:16];
      case (op)
        6'h08, 6'h09: v = a + se;
        6'h0A: v = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0;
        6'h0B: v = (a < se) ? 32'd1 : 32'd0;
        6'h0C: v = a & ze;
        6'h0D: v = a | ze;
        6'h0E: v = a ^ ze;
        6'h0F: v = {ins[15:0], 16'h0};
        default: begin wb = 0; ill = 1; end
      endcase
    end
  endfunction

  // md: 1 mult, 2 multu, 3 div, 4 divu
  function automatic void md_compute(input int md, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo);
    int ia, ib;
    longint sp;
    longint unsigned up;
    ia = a;
    ib = b;
    hi = 0; lo = 0;
    case (md)
      1: begin sp = longint'(ia) * longint'(ib); {hi, lo} = sp; end
      2: begin up = {32'h0, a} * {32'h0, b}; {hi, lo} = up; end
      3: begin
        if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else begin
          sp = longint'(ia) / longint'(ib); lo = sp[31:0];
          sp = longint'(ia) % longint'(ib); hi = sp[31:0];
        end
      end
      default: begin
        if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
  endfunction

  // Reference model, advanced on every rising edge
  always @(posedge clk) begin
    bit          wb, ill;
    logic [4:0]  d;
    logic [31:0] v, a, b;
    int          md;
    wb = 0; d = 0; v = 0;
    if (reset) begin
      e_res = 0; e_dest = 0; e_rv = 0; e_ill = 0; e_done = 0;
      m_hi = 0; m_lo = 0; m_busy = 0; m_acc = 0;
    end else begin
      e_rv = 0; e_ill = 0; e_done = 0; m_acc = 0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin m_hi = p_hi; m_lo = p_lo; e_done = 1; m_busy = 0; end
      end else if (in_valid) begin
        m_acc = 1;
        a = m_gpr[instruction[25:21]];
        b = m_gpr[instruction[20:16]];
        model_decode(instruction, a, b, m_hi, m_lo, wb, d, v, ill, md);
        if (wb) begin e_rv = 1; e_res = v; e_dest = d; end
        e_ill = ill;
        if (md != 0) begin md_compute(md, a, b, p_hi, p_lo); m_busy = 1; m_cnt = 32; end
      end
    end
    if (load_en && load_addr != 5'd0) m_gpr[load_addr] = load_data;
    if (wb && d != 5'd0) m_gpr[d] = v;
    e_zero  = e_rv && (e_res == 0);
    e_ready = !m_busy;
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(e_ready));
      chk("result_valid", 32'(result_valid), 32'(e_rv));
      chk("result", result, e_res);
      chk("dest", 32'(dest), 32'(e_dest));
      chk("Zero_flag", 32'(Zero_flag), 32'(e_zero));
      chk("illegal", 32'(illegal), 32'(e_ill));
      chk("md_done", 32'(md_done), 32'(e_done));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] a, input logic [31:0] d);
    load_en = 1; load_addr = a; load_data = d;
    tick();
    load_en = 0;
  endtask

  task automatic issue(input logic [31:0] ins);
    int g;
    g = 0;
    while (m_busy && g < 200) begin tick(); g++; end
    if (m_busy) chk("issue wait", 32'(m_busy), 32'd0);
    in_valid = 1; instruction = ins;
    tick();
    in_valid = 0;
  endtask

  function automatic logic [31:0] rand_data();
    case ($urandom_range(7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int k;
    r = $urandom;
    r[25:21] = 5'($urandom_range(7));
    r[20:16] = 5'($urandom_range(7));
    r[15:11] = 5'($urandom_range(7));
    k = $urandom_range(99);
    if (k < 45) begin
      r[31:26] = 6'h00;
      case ($urandom_range(13))
        0: r[5:0] = 6'h20;  1: r[5:0] = 6'h21;  2: r[5:0] = 6'h22;  3: r[5:0] = 6'h23;
        4: r[5:0] = 6'h24;  5: r[5:0] = 6'h25;  6: r[5:0] = 6'h26;  7: r[5:0] = 6'h27;
        8: r[5:0] = 6'h2A;  9: r[5:0] = 6'h2B;  10: r[5:0] = 6'h00; 11: r[5:0] = 6'h02;
        default: r[5:0] = 6'h03;
      endcase
    end else if (k < 85) begin
      r[31:26] = 6'(8 + $urandom_range(7));
      case ($urandom_range(7))
        0: r[15:0] = 16'h7FFF;
        1: r[15:0] = 16'h8000;
        2: r[15:0] = 16'hFFFF;
        3: r[15:0] = 16'h0000;
        default: ;
      endcase
    end else if (k < 92) begin
      r[31:26] = 6'h00;
      r[5:0] = ($urandom_range(1) == 0) ? 6'h10 : 6'h12;
    end else if (k < 97) begin
      r[31:26] = 6'h00;
      r[5:0] = 6'(6'h18 + $urandom_range(3));
    end else begin
      if ($urandom_range(1) == 0) r[31:26] = 6'h23;
      else begin r[31:26] = 6'h00; r[5:0] = 6'h01; end
    end
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1;
    chk("lit reset result", result, 32'h0);
    chk("lit reset in_ready", 32'(in_ready), 32'd1);
    chk("lit reset result_valid", 32'(result_valid), 32'd0);
    chk("lit reset md_done", 32'(md_done), 32'd0);
    reset = 0;
    for (int i = 1; i < 32; i++) load(5'(i), $urandom);

    // ALU basics
    load(1, 32'd3); load(2, 32'd2);
    issue(32'h0022_1820);
    chk("lit add result", result, 32'd5);
    chk("lit add dest", 32'(dest), 32'd3);
    chk("lit add zero", 32'(Zero_flag), 32'd0);
    issue(32'h0021_2022);
    chk("lit sub result", result, 32'd0);
    chk("lit sub zero", 32'(Zero_flag), 32'd1);

    // Shifts with back-to-back dependency
    load(5, 32'h8000_0000);
    issue(32'h0005_3103);
    chk("lit sra", result, 32'hF800_0000);
    issue(32'h0006_3902);
    chk("lit srl dep", result, 32'h0F80_0000);

    // Immediates
    load(8, 32'hFFFF_FFFF);
    issue(32'h3109_8000);
    chk("lit andi", result, 32'h0000_8000);
    issue(32'h2009_8000);
    chk("lit addi", result, 32'hFFFF_8000);
    issue(32'h3C09_1234);
    chk("lit lui", result, 32'h1234_0000);

    // Signed multiply timing and result
    load(1, 32'hFFFF_FFFD); load(2, 32'd7);
    issue(32'h0022_0018);
    n = 0;
    while (!in_ready && n < 100) begin n++; tick(); end
    chk("lit mult busy cycles", n, 32'd32);
    chk("lit mult md_done", 32'(md_done), 32'd1);
    issue(32'h0000_5010);
    chk("lit mult hi", result, 32'hFFFF_FFFF);
    issue(32'h0000_5812);
    chk("lit mult lo", result, 32'hFFFF_FFEB);

    // Signed divide and divide by zero
    load(1, 32'hFFFF_FFF9); load(2, 32'd2);
    issue(32'h0022_001A);
    issue(32'h0000_5812);
    chk("lit div lo", result, 32'hFFFF_FFFD);
    issue(32'h0000_5010);
    chk("lit div hi", result, 32'hFFFF_FFFF);
    load(1, 32'd9);
    issue(32'h0020_001B);
    issue(32'h0000_5812);
    chk("lit divu0 lo", result, 32'hFFFF_FFFF);
    issue(32'h0000_5010);
    chk("lit divu0 hi", result, 32'd9);

    // Unsupported opcode
    issue(32'h8C22_0000);
    chk("lit illegal", 32'(illegal), 32'd1);
    chk("lit illegal no wb", 32'(result_valid), 32'd0);

    // Reset in the middle of a multiply
    issue(32'h0022_0018);
    repeat (9) tick();
    reset = 1;
    tick();
    chk("lit reset abort in_ready", 32'(in_ready), 32'd1);
    reset = 0;
    n = 0;
    repeat (40) begin if (md_done) n++; tick(); end
    chk("lit no md_done after abort", n, 32'd0);
    issue(32'h0000_5010);
    chk("lit hi cleared", result, 32'h0);

    // Randomized traffic; an unaccepted offer is held until taken
    for (int c = 0; c < 3000; c++) begin
      if (!(in_valid && !m_acc)) begin
        in_valid = ($urandom_range(3) != 0);
        instruction = rand_instr();
      end
      load_en   = ($urandom_range(3) == 0);
      load_addr = 5'($urandom_range(7));
      load_data = rand_data();
      reset     = ($urandom_range(499) == 0);
      tick();
    end
    in_valid = 0; load_en = 0; reset = 0;
    repeat (40) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_exec_unit.md
Name: mips_exec_unit

Overview:
- Successor to the combinational MIPS ALU datapath.
- Adds an internal 32-entry GPR file, registered writeback, and an iterative multiply/divide unit with HI/LO.
- Width-parametrised, with a valid/ready instruction handshake.
- Sits between instruction fetch/decode and future memory stage; bench loads GPRs through a side load port.

Parameters:
- W, 32, data width; 32 or 64. Immediates sign-/zero-extend to W.
- MUL_STEP, 1, multiplier bits retired per cycle (1, 2 or 4). Divide always 1 bit/cycle.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  instruction valid
- in_ready  output  1  unit can accept an instruction
- instruction  input  32  MIPS instruction word
- load_en  input  1  side-port GPR write
- load_addr  input  5  side-port register index
- load_data  input  W  side-port data
- result  output  W  registered writeback value
- dest  output  5  register written
- result_valid  output  1  one-cycle pulse per GPR writeback
- Zero_flag  output  1  result == 0, qualified by result_valid
- illegal  output  1  one-cycle pulse: unsupported opcode/funct accepted
- md_done  output  1  one-cycle pulse when HI/LO update

Behaviour:
- Reset: result=0, dest=0, result_valid=0, Zero_flag=0, illegal=0, md_done=0, HI=LO=0, state IDLE, in_ready=1. GPRs are not cleared; r0 always reads 0.
- Accept = in_valid && in_ready at a rising edge.
- Operands are read combinationally from the GPRs in the accept cycle. Writeback occurs at that same edge, so a back-to-back dependent instruction sees the new value (no hazard).
- ALU ops: latency 1. result/dest/Zero_flag are valid with result_valid in the cycle after accept.
- R-type (op 0):
  - add 20, addu 21, sub 22, subu 23, and 24, or 25, xor 26, nor 27, slt 2A, sltu 2B → rd.
  - sll 00, srl 02, sra 03 → rd; shift rt by shamt.
  - mfhi 10, mflo 12 → rd.
  - mult 18, multu 19, div 1A, divu 1B: start MD; no GPR writeback.
- I-type → rt:
  - addi 08, addiu 09, slti 0A, sltiu 0B: sign-extended imm.
  - andi 0C, ori 0D, xori 0E: zero-extended imm.
  - lui 0F: sign-extend of {imm,16'b0}.
- Other op/funct: illegal pulses; no writeback, no HI/LO change.
- Destination r0: result_valid still pulses with dest=0; the register is not written.
- Load port: writes on any edge when load_en=1 (r0 ignored). If it collides with a writeback to the same register, the writeback wins.
- FSM:
  - IDLE → MUL on mult/multu; count = W/MUL_STEP cycles.
  - IDLE → DIV on div/divu; count = W cycles; restoring division on magnitudes, sign fix in the final cycle.
  - MUL/DIV: in_ready=0. On count expiry, HI/LO are written, md_done pulses, and the FSM returns to IDLE. in_ready=1 in the cycle md_done is high.
- Signed results:
  - mult: HI:LO = 2W-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder carrying the dividend's sign.
- Divide by zero (both signednesses): LO = all ones, HI = dividend. No trap.
- Reset mid-MD: aborts the operation; HI/LO=0; IDLE next cycle.
- in_valid with in_ready=0: ignored; the source must hold.

Optional Feature:
- MIPS_OVF_TRAP_EN defined: signed overflow on add/sub/addi suppresses writeback (result_valid=0) and pulses output ovf_trap for one cycle (port exists only when the macro is defined).
- Undefined: add/sub/addi wrap exactly like addu/subu/addiu.

Test Plan:
- Load r1=3, r2=2; add r3,r1,r2 (0x00221820) → next cycle result=5, dest=3, Zero_flag=0. Then sub r4,r1,r1 → result=0, Zero_flag=1.
- r5=0x80000000; sra r6,r5,4 → 0xF8000000. Next cycle: srl r7,r6,4 → 0x0F800000 (back-to-back dependency).
- r8=0xFFFFFFFF: andi r9,r8,0x8000 → 0x00008000; addi r9,r0,0x8000 → 0xFFFF8000; lui r9,0x1234 → 0x12340000.
- r1=0xFFFFFFFD, r2=7, mult r1,r2 (MUL_STEP=1) → in_ready low 32 cycles, md_done pulse; mfhi → 0xFFFFFFFF, mflo → 0xFFFFFFEB.
- div -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 9/0 → LO=0xFFFFFFFF, HI=9. Opcode 0x23 → illegal pulse, no writeback.
- Reset asserted at MD cycle 10 → in_ready=1 next cycle, no md_done, mfhi → 0.
